// File: rtl/serial_receiver.sv
// serial_receiver
//   Serial-to-parallel receiver for the load/shift/done link. A start strobe
//   (ST) sampled in IDLE opens a frame. WIDTH serial bits (SIN) are then
//   captured on consecutive edges and assembled into a parallel word. The word
//   is presented on DOUT with RDY held high until the consumer acknowledges it
//   (ACK). A frame that completes while an unacknowledged word is pending is
//   dropped, and OVR is set.
//
// Parameters
//   WIDTH      bits per frame (2..32)
//   MSB_FIRST  1: first received bit lands in DOUT[WIDTH-1]
//              0: first received bit lands in DOUT[0]
//
// Ports
//   Cin   in   clock, rising edge
//   RSTn  in   asynchronous active-low reset
//   ST    in   frame start strobe, sampled only in IDLE
//   SIN   in   serial data bit, sampled every cycle in SHIFT
//   ACK   in   consumer acknowledge, clears RDY and OVR
//   SH    out  high while bits are being captured
//   DOUT  out  last completed frame
//   RDY   out  DOUT holds an unacknowledged frame
//   OVR   out  sticky: a frame completed and was dropped while RDY=1
module serial_receiver #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             Cin,
  input  logic             RSTn,
  input  logic             ST,
  input  logic             SIN,
  input  logic             ACK,
  output logic             SH,
  output logic [WIDTH-1:0] DOUT,
  output logic             RDY,
  output logic             OVR
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic             done;

  // The word includes the bit being sampled on this edge, so the completed
  // frame can go straight to DOUT without an extra cycle.
  always_comb begin
    word = '0;
    if (MSB_FIRST) word = {sr[WIDTH-2:0], SIN};
    else           word = {SIN, sr[WIDTH-1:1]};
    done = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge Cin or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      SH    <= 1'b0;
      DOUT  <= '0;
      RDY   <= 1'b0;
      OVR   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ST) begin
            state <= SHIFT;
            sr    <= '0;
            cnt   <= '0;
            SH    <= 1'b1;
          end
        end
        SHIFT: begin
          sr  <= word;
          cnt <= cnt + 1'b1;
          if (done) begin
            state <= IDLE;
            SH    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          SH    <= 1'b0;
        end
      endcase

      // OVR can only be set while RDY=1, so accepting a word (RDY=0 or
      // simultaneous ACK) always leaves OVR clear.
      if (done) begin
        if (!RDY || ACK) begin
          DOUT <= word;
          RDY  <= 1'b1;
          OVR  <= 1'b0;
        end else begin
          OVR  <= 1'b1;
        end
      end else if (ACK) begin
        RDY <= 1'b0;
        OVR <= 1'b0;
      end
    end
  end

endmodule

// File: doc/serial_receiver.md
# serial_receiver

Serial-to-parallel receiving end of the shift-register load/shift/done protocol. It captures a start strobe followed by WIDTH serial bits, assembles them into a parallel word, and presents that word with a ready flag that stays up until the consumer acknowledges it. It sits at the far end of the serial link, opposite the load/shift controller, and feeds a parallel consumer.

## Interface
- WIDTH, 8: bits per frame; legal range 2–32.
- MSB_FIRST, 1: 1 = first received bit lands in DOUT[WIDTH-1]; 0 = first received bit lands in DOUT[0].

- Cin  input  1  clock; all state changes on the rising edge.
- RSTn  input  1  reset, asynchronous, active-low.
- ST  input  1  frame start strobe; sampled only in IDLE.
- SIN  input  1  serial data bit; sampled every cycle in SHIFT.
- ACK  input  1  consumer acknowledge; clears RDY and OVR.
- SH  output  1  high while in SHIFT, i.e. while bits are being captured.
- DOUT  output  WIDTH  last completed frame.
- RDY  output  1  DOUT holds an unacknowledged frame.
- OVR  output  1  sticky flag: a frame completed and was dropped while RDY=1.

## Operation
- Datapath:
  - WIDTH-bit shift register.
  - Bit counter, width clog2(WIDTH+1).
  - DOUT holding register.
- State machine (Moore): IDLE, SHIFT.
- IDLE:
  - SH=0.
  - ST=1 → SHIFT; counter cleared to 0; shift register cleared.
  - ST=0 → stay in IDLE.
- SHIFT:
  - SH=1.
  - Each edge: SIN is shifted in and the counter increments.
  - MSB_FIRST=1: shift left, SIN enters bit 0.
  - MSB_FIRST=0: shift right, SIN enters bit WIDTH-1.
  - ST is ignored.
  - The edge that captures bit WIDTH completes the frame and returns the FSM to IDLE.
- Frame completion, using the assembled word (shift register plus the current SIN):
  - RDY=0, or ACK=1 on the same edge: DOUT ← word, RDY ← 1.
  - RDY=1 and ACK=0: word dropped, DOUT unchanged, OVR ← 1, RDY stays 1.
- ACK with no completion on that edge:
  - RDY ← 0 and OVR ← 0.
  - DOUT holds its value.
  - ACK while RDY=0 has no effect.
- Reset, asserted at any time including mid-frame:
  - Immediately forces FSM=IDLE, counter=0, shift register=0, DOUT=0, SH=0, RDY=0, OVR=0.
  - A partial frame is discarded.
  - After release, the FSM waits for a fresh ST.

## Timing
- ST=1 sampled at edge k (FSM in IDLE) → SH=1 from just after edge k.
- Bits are sampled at edges k+1 … k+WIDTH.
- After edge k+WIDTH: DOUT valid, RDY=1, SH=0.
- Latency from the ST edge to RDY is WIDTH cycles.
- The earliest next ST is sampled at edge k+WIDTH+1, so the minimum frame period is WIDTH+1 cycles.
- RDY deasserts the cycle after the ACK edge.
- Simultaneous ACK and completion: RDY stays 1 with the new DOUT; OVR is cleared.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, WIDTH=8, MSB_FIRST=1, then ST=1 for one cycle and SIN=1,0,1,0,0,1,0,1 → SH=1 for exactly 8 cycles; after the 8th edge DOUT=8'hA5, RDY=1; ACK=1 for one cycle → RDY=0, DOUT stays 8'hA5.
- Same stimulus with MSB_FIRST=0 → DOUT=8'hA5 bit-reversed = 8'hA5 (palindrome check); repeat with bits 1,0,0,0,0,0,0,0 → DOUT=8'h01.
- Overrun:
  - Frame 8'h3C received, no ACK.
  - Second frame 8'hFF received → DOUT=8'h3C, RDY=1, OVR=1.
  - ACK → RDY=0, OVR=0.
- Simultaneous events: frame 8'h11 pending, ACK asserted on the completion edge of frame 8'h22 → DOUT=8'h22, RDY=1, OVR=0.
- ST held high throughout SHIFT → no restart; counter reaches 8 and DOUT is correct; ST still high in IDLE → a new frame begins the next edge.
- RSTn pulsed low after the 4th bit → all outputs 0 asynchronously; the following full frame 8'hC3 is received correctly, with no leftover bits from the aborted frame.
